kw11l_clock: RTL

KW11L_CLOCK -- requirements
Module: kw11l_clock

---
 rtl/kw11l_clock_pkg.sv | 13 +
 rtl/kw11l_clock.sv | 95 +++++++++
 2 files changed

// File: rtl/kw11l_clock_pkg.sv
// Shared definitions for the KW11-L line clock: interrupt handshake states
// and the default interrupt vector.
package kw11l_clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } irq_state_e;

  localparam logic [15:0] KW11L_VEC_DEFAULT = 16'o000100;

endpackage

// File: rtl/kw11l_clock.sv
// KW11-L line-time clock: CSR at 177546 with monitor/ie bits, 50 Hz tick
// capture and a single-level vectored interrupt handshake.
module kw11l_clock
  import kw11l_clock_pkg::*;
#(
  parameter logic [15:0] VEC = KW11L_VEC_DEFAULT
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_sel_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic        tick_i,
  input  logic        tick_ena_i,
  output logic        irq_o,
  input  logic        istb_i,
  output logic        iack_o,
  output logic [15:0] ivec_o
);

  localparam int MON_BIT = 7;
  localparam int IE_BIT  = 6;

  logic       ack_q, ack_d;
  logic       ie_q, ie_d;
  logic       mon_q, mon_d;
  logic       pend_q, pend_d;
  irq_state_e state_q, state_d;

  logic wr_en;
  logic tick_ev;

  // Only the low byte lane carries CSR bits; the rest of the bus is ignored.
  logic unused_bits;
  assign unused_bits = ^{wb_sel_i[1], wb_dat_i[15:8], wb_dat_i[5:0]};

  assign wb_ack_o = wb_stb_i & ack_q;
  assign wr_en    = wb_ack_o & wb_we_i & wb_sel_i[0];
  assign tick_ev  = tick_i & tick_ena_i;

  assign wb_dat_o = {8'b0, mon_q, ie_q, 6'b0};
  assign irq_o    = (state_q == ST_REQ);
  assign iack_o   = (state_q == ST_ACK);
  assign ivec_o   = (state_q == ST_ACK) ? VEC : 16'h0000;

  always_comb begin
    ack_d = wb_stb_i & ~ack_q;
    ie_d  = wr_en ? wb_dat_i[IE_BIT] : ie_q;

    // Software can only clear monitor; a tick in the same cycle wins.
    mon_d = mon_q;
    if (wr_en && !wb_dat_i[MON_BIT]) mon_d = 1'b0;
    if (tick_ev)                     mon_d = 1'b1;

    pend_d = pend_q;
    if (state_q == ST_REQ && istb_i) pend_d = 1'b0;
    if (wr_en && !wb_dat_i[IE_BIT])  pend_d = 1'b0;
    if (tick_ev && ie_d)             pend_d = 1'b1;
  end

  // Next-state uses pend_d so a request rises the cycle after the tick and
  // drops the cycle after a write that disables interrupts.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (pend_d) state_d = ST_REQ;
      ST_REQ: begin
        if (istb_i)       state_d = ST_ACK;
        else if (!pend_d) state_d = ST_IDLE;
      end
      ST_ACK:  if (!istb_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q   <= 1'b0;
      ie_q    <= 1'b0;
      mon_q   <= 1'b1;
      pend_q  <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      ack_q   <= ack_d;
      ie_q    <= ie_d;
      mon_q   <= mon_d;
      pend_q  <= pend_d;
      state_q <= state_d;
    end
  end

endmodule
